// File: rtl/mdu_iter.sv
// ---------------------------------------------------------------------------
// mdu_iter -- iterative multiply/divide unit for the MIPS5 EX stage.
//
// Executes MULT, MULTU, DIV and DIVU over 32 iterations and owns the
// architectural HI/LO registers. MTHI/MTLO writes are serviced while idle.
//
// Every operation takes 34 cycles from the start edge to done:
//   cycle 0      start sampled
//   cycles 1-32  CALC, one multiplier or quotient bit per cycle
//   cycle 33     FIX, sign correction and HI/LO write
//   cycle 34     done pulse, new HI/LO visible, unit idle again
//
// Build option:
//   MDU_DIV_EN  defined   : DIV/DIVU implemented (restoring division).
//               undefined : divider removed. A DIV/DIVU start stays idle
//                           and pulses done one cycle later; HI/LO unchanged.
//
// Ports:
//   clk     in   1  clock, rising edge
//   rst_n   in   1  synchronous reset, active low
//   start   in   1  launch md_op (honoured only when idle)
//   md_op   in   2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   data1   in  32  multiplicand / dividend (rs)
//   data2   in  32  multiplier / divisor (rt)
//   cancel  in   1  pipeline flush, aborts an operation, beats start
//   hi_we   in   1  MTHI write enable (idle only)
//   lo_we   in   1  MTLO write enable (idle only)
//   wdata   in  32  MTHI/MTLO write data
//   busy    out  1  operation in flight
//   done    out  1  one-cycle pulse, HI/LO updated
//   hi      out 32  HI register
//   lo      out 32  LO register
// ---------------------------------------------------------------------------
module mdu_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic        cancel,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]  state_reg;
    logic [4:0]  cnt_reg;
    logic        done_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    // Multiply: acc_reg is the 64-bit product register, multiplier in the low
    // half shifting out as product bits shift in. Divide: acc_reg[31:0] holds
    // the dividend shifting out of bit 31 while quotient bits shift in at bit 0.
    logic [63:0] acc_reg;
    logic [31:0] opnd_reg;      // multiplicand or divisor (magnitude)
    logic        neg_reg;       // product / quotient must be negated in FIX

    // Operand magnitudes; unsigned ops pass the raw bits through.
    logic        op_signed;
    logic        sign1;
    logic        sign2;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] mul_sum;
    logic [63:0] prod_fix;

    always_comb begin
        op_signed = ~md_op[0];
        sign1     = op_signed & data1[31];
        sign2     = op_signed & data2[31];
        abs1      = sign1 ? -data1 : data1;
        abs2      = sign2 ? -data2 : data2;
        // Shift-add step: the carry out of the upper half becomes bit 63.
        mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
        prod_fix  = neg_reg ? -acc_reg : acc_reg;
    end

`ifdef MDU_DIV_EN
    logic        is_div_reg;
    logic        rneg_reg;      // remainder takes the dividend's sign
    logic        dz_reg;        // divisor was zero
    logic [31:0] dividend_reg;  // original dividend bits for the zero-divisor HI
    logic [31:0] rem_reg;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        // 33-bit partial remainder. Since rem < divisor, the difference lies in
        // [-2^32, 2^32), so bit 32 of a 33-bit subtraction is a valid sign.
        div_shift = {rem_reg, acc_reg[31]};
        div_diff  = div_shift - {1'b0, opnd_reg};
        quo_fix   = neg_reg  ? -acc_reg[31:0] : acc_reg[31:0];
        rem_fix   = rneg_reg ? -rem_reg       : rem_reg;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 5'd0;
            done_reg  <= 1'b0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            acc_reg   <= 64'd0;
            opnd_reg  <= 32'd0;
            neg_reg   <= 1'b0;
`ifdef MDU_DIV_EN
            is_div_reg   <= 1'b0;
            rneg_reg     <= 1'b0;
            dz_reg       <= 1'b0;
            dividend_reg <= 32'd0;
            rem_reg      <= 32'd0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start && !cancel) begin
`ifdef MDU_DIV_EN
                        if (md_op[1]) begin
                            state_reg    <= S_CALC;
                            cnt_reg      <= 5'd0;
                            is_div_reg   <= 1'b1;
                            acc_reg      <= {32'd0, abs1};
                            opnd_reg     <= abs2;
                            rem_reg      <= 32'd0;
                            neg_reg      <= sign1 ^ sign2;
                            rneg_reg     <= sign1;
                            dz_reg       <= (data2 == 32'd0);
                            dividend_reg <= data1;
                        end
`else
                        if (md_op[1]) begin
                            // No divider: acknowledge immediately, HI/LO untouched.
                            done_reg <= 1'b1;
                        end
`endif
                        else begin
                            state_reg <= S_CALC;
                            cnt_reg   <= 5'd0;
                            acc_reg   <= {32'd0, abs2};
                            opnd_reg  <= abs1;
                            neg_reg   <= sign1 ^ sign2;
`ifdef MDU_DIV_EN
                            is_div_reg <= 1'b0;
`endif
                        end
                    end else begin
                        // A honoured start drops any simultaneous MTHI/MTLO.
                        if (hi_we) hi_reg <= wdata;
                        if (lo_we) lo_reg <= wdata;
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        state_reg <= S_IDLE;
                    end else begin
`ifdef MDU_DIV_EN
                        if (is_div_reg) begin
                            if (!div_diff[32]) begin
                                rem_reg       <= div_diff[31:0];
                                acc_reg[31:0] <= {acc_reg[30:0], 1'b1};
                            end else begin
                                rem_reg       <= div_shift[31:0];
                                acc_reg[31:0] <= {acc_reg[30:0], 1'b0};
                            end
                        end else
`endif
                        begin
                            acc_reg <= {mul_sum, acc_reg[31:1]};
                        end
                        cnt_reg <= cnt_reg + 5'd1;
                        if (cnt_reg == 5'd31) state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    state_reg <= S_IDLE;
                    if (!cancel) begin
                        done_reg <= 1'b1;
`ifdef MDU_DIV_EN
                        if (is_div_reg) begin
                            hi_reg <= dz_reg ? dividend_reg : rem_fix;
                            lo_reg <= dz_reg ? 32'hFFFF_FFFF : quo_fix;
                        end else
`endif
                        begin
                            hi_reg <= prod_fix[63:32];
                            lo_reg <= prod_fix[31:0];
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_reg != S_IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the MIPS5 EX stage, the multi-cycle counterpart of the single-cycle ALU. It executes MULT, MULTU, DIV and DIVU over 32 iterations and owns the architectural HI/LO registers. It also services MTHI/MTLO writes. Handshake: start/busy/done, plus a cancel for pipeline flush.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst_n` input 1: synchronous reset, active-low, sampled on the `clk` rising edge.
- `start` input 1: launch the operation selected by `md_op`; honoured only in IDLE.
- `md_op` input 2: operation select. 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- `data1` input 32: multiplicand / dividend (rs).
- `data2` input 32: multiplier / divisor (rt).
- `cancel` input 1: flush; aborts an in-flight operation.
- `hi_we` input 1: MTHI write enable.
- `lo_we` input 1: MTLO write enable.
- `wdata` input 32: MTHI/MTLO write data.
- `busy` output 1: operation in flight; the pipeline stalls HI/LO readers while it is high.
- `done` output 1: one-cycle pulse; HI/LO updated and valid.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- States:
  - IDLE: `busy`=0.
  - CALC: 32 iterations, counter 0..31.
  - FIX: sign correction and HI/LO write.
- Start:
  - On an edge with `start`=1 in IDLE, latch `md_op`.
  - Latch operands as absolute values for signed ops (MULT/DIV), raw for unsigned.
  - Record the result sign, then go to CALC.
- MULT/MULTU: radix-2 shift-add, 64-bit product register, one multiplier bit per cycle.
- DIV/DIVU: restoring division, one quotient bit per cycle, 33-bit partial remainder.
- FIX:
  - Negate the product if the result sign is negative.
  - For signed divide, negate the quotient when the operand signs differ; the remainder takes the dividend's sign (truncate toward zero).
  - Write HI=product[63:32] / remainder and LO=product[31:0] / quotient.
  - Return to IDLE and pulse `done` in the following cycle.
- Divide by zero: LO=32'hFFFFFFFF, HI=dividend (original, unsigned bits); full latency is still used.
- Signed overflow (32'h80000000 / 32'hFFFFFFFF): LO=32'h80000000, HI=0.
- MTHI/MTLO: in IDLE, `hi_we`/`lo_we` write `wdata` at the edge; both may be asserted together. Writes are dropped while `busy`=1.
- Simultaneous `start` and `hi_we`/`lo_we` in IDLE: start wins, write dropped.
- `start` while busy: ignored, no queueing.
- `cancel`:
  - Any state goes to IDLE at the next edge.
  - HI/LO unchanged, no `done`.
  - `cancel` outranks `start` on the same edge.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0. This applies mid-operation too; all in-flight results are discarded.
- Cycle numbering: `start` sampled at end of cycle 0.
  - Cycles 1–32: CALC, `busy`=1.
  - Cycle 33: FIX, `busy`=1.
  - Cycle 34: `done`=1, `busy`=0, new `hi`/`lo` visible.
- Latency: 34 cycles for every operation and every operand value, including zero divisor.
- Back-to-back: a new `start` is accepted in the cycle where `done`=1.
- `done` is registered; it is never high for more than one cycle.
- `hi`/`lo` are registered outputs, stable except at the FIX edge or an MTHI/MTLO write edge.

## Configuration
- `MDU_DIV_EN` defined: DIV/DIVU are implemented as specified above.
- `MDU_DIV_EN` undefined:
  - Divider datapath is removed.
  - A `start` with `md_op`=DIV/DIVU goes IDLE→IDLE with `busy` held 0 and `done` pulsed in cycle 1; HI/LO unchanged.
  - MULT/MULTU are unaffected.

## Test plan
- Reset with `start` high, then release: `hi`=`lo`=0, `busy`=0, `done`=0. Assert `rst_n`=0 in cycle 10 of a MULT: no `done`, HI/LO=0.
- MULT -3×5 (32'hFFFFFFFD, 5): `done` in cycle 34, HI=32'hFFFFFFFF, LO=32'hFFFFFFF1. MULTU 32'hFFFFFFFF×32'hFFFFFFFF gives HI=32'hFFFFFFFE, LO=32'h00000001.
- DIV -7/2: LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU 7/0: LO=32'hFFFFFFFF, HI=7. DIV 32'h80000000/32'hFFFFFFFF: LO=32'h80000000, HI=0.
- `start` pulse during cycle 5 of a MULT: ignored, first result unchanged. MTHI 32'h1234 during busy is dropped; the same write in IDLE sets HI=32'h1234 at that edge.
- `cancel` in cycle 20 of DIVU 100/3 after HI/LO preloaded to 32'hA/32'hB: `busy`=0 next cycle, no `done`, HI/LO stay 32'hA/32'hB.
- Back-to-back: second `start` MULTU 6×7 in the `done` cycle of the first op produces LO=42 exactly 34 cycles later. Without `MDU_DIV_EN`, DIV start gives `done` in cycle 1, HI/LO unchanged.
